// File: rtl/jtag_tdr_if.sv
// Signal bundle between the TAP controller / TDO mux side and a test data register.
interface jtag_tdr_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sel;
    logic             bypass;
    logic             capture_dr;
    logic             shift_dr;
    logic             update_dr;
    logic             tdi;
    logic [WIDTH-1:0] capture_data;
    logic             tdo;
    logic [WIDTH-1:0] update_data;
    logic             update_valid;
    logic             length_err;

    // TAP side: drives state decodes and serial/parallel inputs
    modport master (
        output sel, bypass, capture_dr, shift_dr, update_dr, tdi, capture_data,
        input  tdo, update_data, update_valid, length_err
    );

    // Register side
    modport slave (
        input  sel, bypass, capture_dr, shift_dr, update_dr, tdi, capture_data,
        output tdo, update_data, update_valid, length_err
    );
endinterface

// File: rtl/jtag_tdr.sv
// Parametrised JTAG test data register: parallel capture, LSB-first serial shift,
// update latch with optional exact-length check, and a runtime single-bit bypass mode.
module jtag_tdr #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter bit               STRICT_LEN = 1'b1
) (
    input  logic        i_tck,
    input  logic        i_trst_n,
    jtag_tdr_if.slave   bus
);
    // Counter saturates at WIDTH+1 so any over-length shift stays distinguishable.
    localparam int unsigned    CntW   = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntMax  = CntW'(WIDTH + 1);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_upd;
    logic [CntW-1:0]  r_cnt;
    logic             r_valid;
    logic             r_err;
    logic             r_tdo;

    logic [WIDTH-1:0] w_sr_nxt;
    logic [WIDTH-1:0] w_upd_nxt;
    logic [CntW-1:0]  w_cnt_nxt;
    logic [CntW-1:0]  w_cnt_inc;
    logic             w_valid_nxt;
    logic             w_err_nxt;
    logic             w_len_ok;

    assign w_cnt_inc = (r_cnt == CntMax) ? CntMax : r_cnt + 1'b1;
    assign w_len_ok  = !STRICT_LEN || (r_cnt == CntFull);

    // Next-state: capture beats shift beats update; nothing acts while deselected
    always_comb begin
        w_sr_nxt    = r_sr;
        w_upd_nxt   = r_upd;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = 1'b0;
        w_err_nxt   = r_err;
        if (bus.sel) begin
            if (bus.capture_dr) begin
                if (bus.bypass) begin
                    w_sr_nxt[0] = 1'b0;
                end else begin
                    w_sr_nxt = bus.capture_data;
                end
                w_cnt_nxt = '0;
                w_err_nxt = 1'b0;
            end else if (bus.shift_dr) begin
                if (bus.bypass) begin
                    w_sr_nxt[0] = bus.tdi;
                end else begin
                    w_sr_nxt           = r_sr >> 1;
                    w_sr_nxt[WIDTH-1]  = bus.tdi;
                end
                w_cnt_nxt = w_cnt_inc;
            end else if (bus.update_dr && !bus.bypass) begin
                if (w_len_ok) begin
                    w_upd_nxt   = r_sr;
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_err_nxt   = 1'b1;
                end
            end
        end
    end

    // Rising-edge state: shift stage, counter, update latch and flags
    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_sr    <= RESET_VAL;
            r_upd   <= RESET_VAL;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sr    <= w_sr_nxt;
            r_upd   <= w_upd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // TDO retimed on the falling edge so it is stable around the next rising edge
    always_ff @(negedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= r_sr[0];
        end
    end

    assign bus.tdo          = r_tdo;
    assign bus.update_data  = r_upd;
    assign bus.update_valid = r_valid;
    assign bus.length_err   = r_err;

endmodule

// File: tb/tb_jtag_tdr.sv
// Scoreboard bench for jtag_tdr: one strict-length instance and one non-strict instance.
module tb_jtag_tdr;
    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'h5A;

    logic tck = 1'b0;
    logic trst_n;

    always #5 tck = ~tck;

    jtag_tdr_if #(.WIDTH(W)) if_s ();
    jtag_tdr_if #(.WIDTH(W)) if_n ();

    jtag_tdr #(.WIDTH(W), .RESET_VAL(RV), .STRICT_LEN(1'b1)) u_dut_s (
        .i_tck    (tck),
        .i_trst_n (trst_n),
        .bus      (if_s.slave)
    );

    jtag_tdr #(.WIDTH(W), .RESET_VAL(RV), .STRICT_LEN(1'b0)) u_dut_n (
        .i_tck    (tck),
        .i_trst_n (trst_n),
        .bus      (if_n.slave)
    );

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [7:0] q_upd_s[$];
    logic [7:0] q_upd_n[$];
    logic       q_tdo[$];
    logic [7:0] last_s;
    logic [7:0] last_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ss, input logic sn, input logic byp, input logic cap,
                         input logic sh, input logic up, input logic t);
        if_s.sel = ss;  if_s.bypass = byp; if_s.capture_dr = cap;
        if_s.shift_dr = sh; if_s.update_dr = up; if_s.tdi = t;
        if_n.sel = sn;  if_n.bypass = byp; if_n.capture_dr = cap;
        if_n.shift_dr = sh; if_n.update_dr = up; if_n.tdi = t;
    endtask

    task automatic set_data(input logic [7:0] d);
        if_s.capture_data = d;
        if_n.capture_data = d;
    endtask

    task automatic push_tdo(input logic [7:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) q_tdo.push_back(v[i]);
    endtask

    // Rising-edge outputs: every pulse must match a queued commit, otherwise data must hold
    task automatic rise_mon();
        if (if_s.update_valid === 1'b1) begin
            if (q_upd_s.size() == 0) check("s_valid_unexpected", if_s.update_valid, 0);
            else begin
                last_s = q_upd_s.pop_front();
                check("s_update_data", if_s.update_data, last_s);
            end
        end else check("s_update_hold", if_s.update_data, last_s);
        if (if_n.update_valid === 1'b1) begin
            if (q_upd_n.size() == 0) check("n_valid_unexpected", if_n.update_valid, 0);
            else begin
                last_n = q_upd_n.pop_front();
                check("n_update_data", if_n.update_data, last_n);
            end
        end else check("n_update_hold", if_n.update_data, last_n);
    endtask

    task automatic fall_mon();
        if (q_tdo.size() != 0) begin
            logic e;
            e = q_tdo.pop_front();
            check("s_tdo", if_s.tdo, e);
        end
    endtask

    task automatic tick();
        @(posedge tck); #1; rise_mon();
        @(negedge tck); #1; fall_mon();
    endtask

    task automatic idle_s();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic shift_s(input logic [15:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, 0, 0, 0, 1, 0, p[i]);
            tick();
        end
    endtask

    task automatic capture_s(input logic [7:0] d);
        set_data(d);
        drive(1, 0, 0, 1, 0, 0, 0);
        tick();
    endtask

    task automatic update_s();
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();
    endtask

    logic [3:0] sel0_pat [6];

    initial begin
        sel0_pat = '{4'b1000, 4'b0100, 4'b0010, 4'b1111, 4'b0111, 4'b0011};
        drive(0, 0, 0, 0, 0, 0, 0);
        set_data(8'h00);
        last_s = RV;
        last_n = RV;

        // Power-on reset, checked without any clock edge
        trst_n = 1'b1;
        #1 trst_n = 1'b0;
        #1;
        check("rst_s_update_data", if_s.update_data, RV);
        check("rst_s_tdo", if_s.tdo, 0);
        check("rst_s_valid", if_s.update_valid, 0);
        check("rst_s_err", if_s.length_err, 0);
        check("rst_n_update_data", if_n.update_data, RV);
        @(negedge tck); #2 trst_n = 1'b1;

        // Normal scan: capture A5, shift in 3C, commit
        push_tdo(8'hA5, 0, 7);
        capture_s(8'hA5);
        check("cap_err", if_s.length_err, 0);
        shift_s(16'h003C, 8);
        q_upd_s.push_back(8'h3C);
        update_s();
        check("scan_err", if_s.length_err, 0);
        idle_s();
        check("scan_pending", q_upd_s.size(), 0);

        // Short shift (7) rejected; a capture clears the flag
        capture_s(8'hC3);
        shift_s(16'h00FF, 7);
        update_s();
        check("len7_err", if_s.length_err, 1);
        capture_s(8'h00);
        check("len7_clear", if_s.length_err, 0);

        // Long shift (9) rejected
        shift_s(16'h01FF, 9);
        update_s();
        check("len9_err", if_s.length_err, 1);
        check("len9_data", if_s.update_data, 8'h3C);

        // Reset mid-shift: asynchronous, no partial update
        shift_s(16'h0003, 2);
        trst_n = 1'b0;
        #1;
        last_s = RV;
        check("mid_rst_update_data", if_s.update_data, RV);
        check("mid_rst_tdo", if_s.tdo, 0);
        check("mid_rst_valid", if_s.update_valid, 0);
        check("mid_rst_err", if_s.length_err, 0);
        #1 trst_n = 1'b1;

        // Shift stage holds RESET_VAL and the counter restarts at 0 after reset
        push_tdo(RV, 0, 7);
        idle_s();
        shift_s(16'h00FF, 8);
        q_upd_s.push_back(8'hFF);
        update_s();
        idle_s();
        check("rstval_pending", q_upd_s.size(), 0);

        // Bypass: single-bit stage, capture loads 0, update does nothing
        q_tdo.push_back(1'b0); q_tdo.push_back(1'b1); q_tdo.push_back(1'b1);
        q_tdo.push_back(1'b0); q_tdo.push_back(1'b1);
        set_data(8'hFF);
        drive(1, 0, 1, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 1, 0, 1); tick();
        drive(1, 0, 1, 0, 1, 0, 1); tick();
        drive(1, 0, 1, 0, 1, 0, 0); tick();
        drive(1, 0, 1, 0, 1, 0, 1); tick();
        drive(1, 0, 1, 0, 0, 1, 0); tick();
        check("byp_err", if_s.length_err, 0);
        check("byp_data", if_s.update_data, 8'hFF);
        drive(1, 0, 1, 0, 0, 0, 0); tick();
        check("byp_tdo_drained", q_tdo.size(), 0);

        // Priority: capture beats shift, shift beats update
        push_tdo(8'h96, 0, 7);
        set_data(8'h96);
        drive(1, 0, 0, 1, 1, 0, 1); tick();
        shift_s(16'h004B, 7);
        drive(1, 0, 0, 0, 1, 1, 1'b0); tick();
        check("prio_su_err", if_s.length_err, 0);
        q_upd_s.push_back(8'h4B);
        update_s();
        idle_s();
        check("prio_pending", q_upd_s.size(), 0);

        // sel=0: strobes toggling must not disturb sr, cnt, latch or flags
        push_tdo(8'h2D, 0, 3);
        capture_s(8'h2D);
        shift_s(16'h0027, 3);
        for (int i = 0; i < 6; i++) begin
            q_tdo.push_back(1'b1);
            drive(0, 0, 0, sel0_pat[i][3], sel0_pat[i][2], sel0_pat[i][1], sel0_pat[i][0]);
            tick();
        end
        check("sel0_err", if_s.length_err, 0);
        check("sel0_valid", if_s.update_valid, 0);
        push_tdo(8'h2D, 4, 7);
        shift_s(16'h0027 >> 3, 5);
        q_upd_s.push_back(8'h27);
        update_s();
        check("sel0_commit_err", if_s.length_err, 0);
        idle_s();
        check("sel0_pending", q_upd_s.size(), 0);

        // Non-strict instance commits after only 3 shifts
        set_data(8'h81);
        drive(0, 1, 0, 1, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 1, 0, 1); tick();
        drive(0, 1, 0, 0, 1, 0, 0); tick();
        drive(0, 1, 0, 0, 1, 0, 1); tick();
        q_upd_n.push_back(8'hB0);
        drive(0, 1, 0, 0, 0, 1, 0); tick();
        check("ns_err", if_n.length_err, 0);
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        check("ns_pending", q_upd_n.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jtag_tdr.md
# jtag_tdr

Parametrised JTAG test data register, successor to the single-bit bypass register. It sits between the TAP controller state decodes and the TDO mux. It captures a parallel WIDTH-bit value, shifts it LSB-first from TDI to TDO, and commits the shifted-in word to a parallel update latch. It adds a runtime bypass mode and an optional shift-length check that rejects updates whose shift count is not exactly WIDTH.

## Interface
Parameters:
- WIDTH, 8, data register length in bits (≥1)
- RESET_VAL, '0, reset value of the shift stage and the update latch (WIDTH bits)
- STRICT_LEN, 1, when 1 an update commits only if exactly WIDTH shifts occurred since the last capture

Ports:
- TCK  input  1  JTAG test clock
- TRST  input  1  reset; asynchronous, active-low
- sel  input  1  IR decode selects this register; all strobes are ignored when low
- bypass  input  1  1 = collapse to a single-bit bypass stage
- CaptureDR  input  1  TAP Capture-DR state
- ShiftDR  input  1  TAP Shift-DR state
- UpdateDR  input  1  TAP Update-DR state
- TDI  input  1  serial data in
- capture_data  input  WIDTH  parallel value loaded on capture
- TDO  output  1  serial data out, changes on falling TCK
- update_data  output  WIDTH  committed parallel value
- update_valid  output  1  one-TCK pulse when update_data is written
- length_err  output  1  sticky flag: last update rejected on length

## Operation
- State: shift stage sr[WIDTH-1:0], update latch, and shift counter cnt. The counter is $clog2(WIDTH+2) bits wide and saturates at WIDTH+1, meaning "too many".
- Strobe priority on each rising TCK edge with sel=1: CaptureDR, then ShiftDR, then UpdateDR. The highest active strobe acts and the others are ignored that cycle.
- With sel=0: sr, cnt, the update latch and length_err hold, and update_valid=0.
- Capture, bypass=0: sr <= capture_data, cnt <= 0, length_err <= 0.
- Capture, bypass=1: sr[0] <= 0, sr[WIDTH-1:1] hold, cnt <= 0, length_err <= 0.
- Shift, bypass=0: sr <= {TDI, sr[WIDTH-1:1]}, and cnt <= min(cnt+1, WIDTH+1).
- Shift, bypass=1: sr[0] <= TDI, other bits hold; cnt behaves the same as for bypass=0.
- Update, bypass=0, with STRICT_LEN=0 or cnt==WIDTH: update_data <= sr, update_valid=1 for that cycle, length_err <= 0.
- Update, bypass=0, otherwise: update_data holds, update_valid=0, length_err <= 1.
- Update, bypass=1: no commit, no pulse, length_err unchanged.
- update_valid is 0 in every cycle without a committing update.
- bypass must be stable from capture to update. If it toggles mid-sequence, the behaviour follows the per-cycle rules above and no recovery is defined.

## Timing
- Reset (TRST=0, asynchronous) sets sr and update_data to RESET_VAL, and cnt, TDO, update_valid and length_err to 0. Reset mid-shift aborts the sequence; no partial update.
- TDO is registered on the falling TCK edge from sr[0], for IEEE 1149.1 compliance.
- Capture-to-TDO latency: capture_data[0] appears on TDO at the falling edge after the capture rising edge. After k shifts, TDO shows the original bit k (k<WIDTH); after that, the TDI bits in order.
- TDI-to-TDO latency: WIDTH TCK cycles with bypass=0, 1 TCK cycle with bypass=1.
- update_data changes on the rising edge of the UpdateDR cycle; update_valid is high for exactly that one TCK period.
- Counter boundary: exactly WIDTH shifts → commit; WIDTH-1 or WIDTH+1 or more shifts → length_err (when STRICT_LEN=1).

## Test plan
- Reset: assert TRST mid-shift with RESET_VAL=8'h5A. Required response: sr and update_data = 8'h5A; TDO, update_valid and length_err = 0 immediately, with no TCK edge needed.
- Normal scan (WIDTH=8, STRICT_LEN=1): capture 8'hA5, shift 8 cycles with TDI = 8'h3C LSB-first, then update. Required response:
  - TDO emits 1,0,1,0,0,1,0,1.
  - update_data = 8'h3C with a single one-cycle update_valid pulse, and length_err = 0.
- Length error: capture, then shift 7 cycles (then, separately, 9 cycles), then update. Required response: length_err = 1, update_data unchanged, no update_valid. A following capture clears length_err.
- Bypass: bypass=1, capture, then shift TDI = 1,1,0,1. Required response:
  - TDO = 0,1,1,0 (delayed by one TCK).
  - Update produces no pulse and no change to update_data.
- Priority and select:
  - CaptureDR and ShiftDR together → capture only.
  - ShiftDR and UpdateDR together → shift only.
  - sel=0 with all strobes toggling → no change to sr, cnt, update_data, update_valid or length_err.
- STRICT_LEN=0: capture, shift 3 cycles, update. Required response: commit of the current sr with an update_valid pulse and length_err = 0.
